// File: rtl/beep_arbiter.sv
// Three-requester fixed-priority beeper arbiter: grants one tone at a time, gates
// it onto fm as a square wave for a timed duration, then holds a silent gap.
module beep_arbiter #(
    parameter int DIV_W     = 16,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [DIV_W-1:0] div0,
    input  logic [DIV_W-1:0] div1,
    input  logic [DIV_W-1:0] div2,
    input  logic [DUR_W-1:0] dur0,
    input  logic [DUR_W-1:0] dur1,
    input  logic [DUR_W-1:0] dur2,
    input  logic             stop,
    output logic [2:0]       ack,
    output logic [2:0]       done,
    output logic             busy,
    output logic             fm
);

    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam int TC_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [TC_W-1:0] GAP_LAST = TC_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [PS_W-1:0]  pc, pc_d;
    logic [TC_W-1:0]  tc, tc_d, dur_last;
    logic [DIV_W-1:0] hc, hc_d, div_q, div_d, sel_div, div_last;
    logic [DUR_W-1:0] dur_q, dur_d, sel_dur;
    logic [2:0]       gnt, gnt_d, ack_d, done_d;
    logic             busy_d, fm_d, tick_last, play_last;

    // pc divides clk into ticks, tc counts ticks within the tone or the gap
    assign tick_last = (pc == PS_LAST);
    assign dur_last  = TC_W'(dur_q) - TC_W'(1);
    assign div_last  = div_q - DIV_W'(1);
    assign play_last = (dur_q == '0) || (tick_last && (tc == dur_last));

    always_comb begin
        state_d = state;
        pc_d    = pc;
        tc_d    = tc;
        hc_d    = hc;
        div_d   = div_q;
        dur_d   = dur_q;
        gnt_d   = gnt;
        sel_div = div0;
        sel_dur = dur0;
        ack_d   = 3'b000;
        done_d  = 3'b000;
        fm_d    = 1'b1;
        case (state)
            IDLE: begin
                if (!stop && (req != 3'b000)) begin
                    if (req[0]) begin
                        gnt_d   = 3'b001;
                        sel_div = div0;
                        sel_dur = dur0;
                    end else if (req[1]) begin
                        gnt_d   = 3'b010;
                        sel_div = div1;
                        sel_dur = dur1;
                    end else begin
                        gnt_d   = 3'b100;
                        sel_div = div2;
                        sel_dur = dur2;
                    end
                    ack_d   = gnt_d;
                    div_d   = sel_div;
                    dur_d   = sel_dur;
                    pc_d    = '0;
                    tc_d    = '0;
                    hc_d    = '0;
                    fm_d    = (sel_div == '0) || (sel_dur == '0);
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (play_last) begin
                    state_d = GAP;
                    done_d  = gnt;
                    pc_d    = '0;
                    tc_d    = '0;
                end else begin
                    pc_d = tick_last ? '0 : pc + PS_W'(1);
                    tc_d = tick_last ? tc + TC_W'(1) : tc;
                    fm_d = fm;
                    // A zero divisor leaves fm parked high for a silent tone
                    if (div_q != '0) begin
                        if (hc == div_last) begin
                            fm_d = ~fm;
                            hc_d = '0;
                        end else begin
                            hc_d = hc + DIV_W'(1);
                        end
                    end
                end
            end
            GAP: begin
                if (stop || (tick_last && (tc == GAP_LAST))) begin
                    state_d = IDLE;
                end else begin
                    pc_d = tick_last ? '0 : pc + PS_W'(1);
                    tc_d = tick_last ? tc + TC_W'(1) : tc;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            tc    <= '0;
            hc    <= '0;
            div_q <= '0;
            dur_q <= '0;
            gnt   <= 3'b000;
            ack   <= 3'b000;
            done  <= 3'b000;
            busy  <= 1'b0;
            fm    <= 1'b1;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            tc    <= tc_d;
            hc    <= hc_d;
            div_q <= div_d;
            dur_q <= dur_d;
            gnt   <= gnt_d;
            ack   <= ack_d;
            done  <= done_d;
            busy  <= busy_d;
            fm    <= fm_d;
        end
    end

endmodule

// File: tb/tb_beep_arbiter.sv
// Scoreboard bench for beep_arbiter: a tone-level model predicts grant/done pulses
// and per-cycle fm/busy, and an independent monitor checks the DUT against them.
module tb_beep_arbiter;

    localparam int DIV_W     = 8;
    localparam int DUR_W     = 4;
    localparam int TICK_DIV  = 50;
    localparam int GAP_TICKS = 2;
    localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       req   = 3'b000;
    logic [DIV_W-1:0] div0  = '0;
    logic [DIV_W-1:0] div1  = '0;
    logic [DIV_W-1:0] div2  = '0;
    logic [DUR_W-1:0] dur0  = '0;
    logic [DUR_W-1:0] dur1  = '0;
    logic [DUR_W-1:0] dur2  = '0;
    logic             stop  = 1'b0;
    logic [2:0]       ack;
    logic [2:0]       done;
    logic             busy;
    logic             fm;

    beep_arbiter #(
        .DIV_W(DIV_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .div0(div0), .div1(div1), .div2(div2),
        .dur0(dur0), .dur1(dur1), .dur2(dur2),
        .stop(stop), .ack(ack), .done(done), .busy(busy), .fm(fm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } pulse_t;

    typedef struct {
        int cyc;
        int fm;
        int busy;
    } sample_t;

    pulse_t  ack_q[$];
    pulse_t  done_q[$];
    sample_t smp_q[$];
    pulse_t  pe;
    sample_t se;
    int      checks = 0;
    int      errors = 0;
    int      free_cyc = 0;

    task automatic check_output(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic void push_smp(input int c, input int f, input int b);
        sample_t e;
        e.cyc  = c;
        e.fm   = f;
        e.busy = b;
        smp_q.push_back(e);
    endfunction

    function automatic void push_ack(input int c, input int v);
        pulse_t e;
        e.cyc = c;
        e.val = v;
        ack_q.push_back(e);
    endfunction

    function automatic void push_done(input int c, input int v);
        pulse_t e;
        e.cyc = c;
        e.val = v;
        done_q.push_back(e);
    endfunction

    // Monitor: pops an expectation whenever the DUT pulses, and checks fm/busy at predicted cycles
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack != 3'b000) begin
                if (ack_q.size() == 0) begin
                    check_output("ack_spurious", int'(ack), 0);
                end else begin
                    pe = ack_q.pop_front();
                    check_output("ack_cycle", cyc, pe.cyc);
                    check_output("ack_value", int'(ack), pe.val);
                end
            end
            if (done != 3'b000) begin
                if (done_q.size() == 0) begin
                    check_output("done_spurious", int'(done), 0);
                end else begin
                    pe = done_q.pop_front();
                    check_output("done_cycle", cyc, pe.cyc);
                    check_output("done_value", int'(done), pe.val);
                end
            end
            if (smp_q.size() > 0 && smp_q[0].cyc == cyc) begin
                se = smp_q.pop_front();
                check_output("fm", int'(fm), se.fm);
                check_output("busy", int'(busy), se.busy);
            end
        end
    end

    function automatic void set_inputs(input int i, input int dv, input int dr);
        if (i == 0) begin
            div0 = DIV_W'(dv);
            dur0 = DUR_W'(dr);
        end else if (i == 1) begin
            div1 = DIV_W'(dv);
            dur1 = DUR_W'(dr);
        end else begin
            div2 = DIV_W'(dv);
            dur2 = DUR_W'(dr);
        end
    endfunction

    // Called at the negedge of a cycle in which the DUT is idle; runs until it is idle again
    task automatic apply_stimulus(input logic [2:0] mask, input int dv[3], input int dr[3],
                                  input bit idle_stop, input int stop_tone, input int stop_off);
        int c, t, g, len, last, s_cyc, n, k, f;
        int clr_at[3];
        bit stopped;
        c     = cyc;
        s_cyc = -10;
        n     = 0;
        for (int i = 0; i < 3; i++) begin
            set_inputs(i, dv[i], dr[i]);
            clr_at[i] = -1;
        end
        req  = mask;
        stop = idle_stop;
        t    = idle_stop ? c + 1 : c;
        if (t > c) push_smp(t, 1, 0);
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                g         = t + 1;
                clr_at[i] = g;
                push_ack(g, 1 << i);
                len     = (dr[i] == 0) ? 1 : dr[i] * TICK_DIV;
                last    = g + len + GAP_CYC - 1;
                stopped = 1'b0;
                if (n == stop_tone) begin
                    s_cyc   = g + (stop_off % (len + GAP_CYC));
                    last    = s_cyc;
                    stopped = 1'b1;
                end
                for (int x = g; x <= last; x++) begin
                    k = x - g;
                    if (k < len && dv[i] != 0 && dr[i] != 0) f = (k / dv[i]) % 2;
                    else f = 1;
                    push_smp(x, f, 1);
                end
                if (!stopped || s_cyc >= g + len) push_done(g + len, 1 << i);
                t = last + 1;
                push_smp(t, 1, 0);
                n++;
            end
        end
        free_cyc = t;
        while (cyc < free_cyc) begin
            @(negedge clk);
            if (idle_stop && cyc == c + 1) stop = 1'b0;
            if (cyc == s_cyc) stop = 1'b1;
            else if (cyc == s_cyc + 1) stop = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (cyc == clr_at[i]) begin
                    req[i] = 1'b0;
                    set_inputs(i, $urandom_range(0, 255), $urandom_range(0, 15));
                end
            end
        end
    endtask

    task automatic reset_mid_tone();
        int c, g;
        int dv[3];
        int dr[3];
        dv = '{10, 0, 0};
        dr = '{2, 0, 0};
        c  = cyc;
        g  = c + 1;
        set_inputs(0, 10, 2);
        req  = 3'b001;
        stop = 1'b0;
        push_ack(g, 1);
        for (int k = 0; k < 5; k++) push_smp(g + k, 0, 1);
        while (cyc < g + 5) @(negedge clk);
        #2;
        ack_q.delete();
        done_q.delete();
        smp_q.delete();
        rst_n = 1'b0;
        #1;
        check_output("reset_async_fm", int'(fm), 1);
        check_output("reset_async_busy", int'(busy), 0);
        check_output("reset_async_ack", int'(ack), 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_output("release_no_grant", int'(ack), 0);
        check_output("release_fm", int'(fm), 1);
        apply_stimulus(3'b001, dv, dr, 1'b0, -1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dv[3];
        int dr[3];
        @(negedge clk);
        @(negedge clk);
        check_output("rst_fm", int'(fm), 1);
        check_output("rst_ack", int'(ack), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_busy", int'(busy), 0);
        #2;
        rst_n = 1'b1;

        dv = '{0, 25, 0};  dr = '{0, 2, 0};
        apply_stimulus(3'b010, dv, dr, 1'b0, -1, 0);
        dv = '{7, 0, 12};  dr = '{1, 0, 1};
        apply_stimulus(3'b101, dv, dr, 1'b0, -1, 0);
        dv = '{5, 3, 0};   dr = '{2, 1, 0};
        apply_stimulus(3'b011, dv, dr, 1'b0, 0, 9);
        dv = '{0, 0, 0};   dr = '{3, 0, 0};
        apply_stimulus(3'b001, dv, dr, 1'b0, -1, 0);
        dv = '{0, 0, 4};   dr = '{0, 0, 0};
        apply_stimulus(3'b100, dv, dr, 1'b0, -1, 0);
        dv = '{0, 6, 9};   dr = '{0, 1, 1};
        apply_stimulus(3'b110, dv, dr, 1'b1, -1, 0);
        dv = '{4, 0, 0};   dr = '{1, 0, 0};
        apply_stimulus(3'b001, dv, dr, 1'b0, 0, 60);
        reset_mid_tone();

        for (int s = 0; s < 20; s++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                dv[i] = $urandom_range(0, 40);
                dr[i] = $urandom_range(0, 3);
            end
            apply_stimulus(3'($urandom_range(1, 7)), dv, dr, ($urandom_range(0, 4) == 0),
                           ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : -1,
                           $urandom_range(0, 300));
        end

        repeat (5) @(negedge clk);
        check_output("ack_pending", ack_q.size(), 0);
        check_output("done_pending", done_q.size(), 0);
        check_output("sample_pending", smp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beep_arbiter.md
BEEP_ARBITER -- requirements
Module: beep_arbiter

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, width of the half-period divisor.
REQ-002 The block SHALL have parameter DUR_W, default 16, width of the tone duration in ticks.
REQ-003 The block SHALL have parameter TICK_DIV, default 50000, clk cycles per duration tick (1 ms at 50 MHz).
REQ-004 The block SHALL have parameter GAP_TICKS, default 20, silent ticks after each tone; legal range is 1 or more.
REQ-005 clk  input  1  system clock, 50 MHz nominal.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 req  input  3  per-requester tone request, level, held until ack; bit 0 is highest priority.
REQ-008 div0, div1, div2  input  DIV_W each  half-period of the requester's tone, in clk cycles.
REQ-009 dur0, dur1, dur2  input  DUR_W each  tone length of the requester's tone, in ticks.
REQ-010 stop  input  1  abort the current tone or gap.
REQ-011 ack  output  3  one-cycle grant pulse, one-hot.
REQ-012 done  output  3  one-cycle completion pulse, one-hot.
REQ-013 busy  output  1  high in PLAY and GAP.
REQ-014 fm  output  1  beeper gate; low = sounding phase, high = silent.

Function
REQ-015 The block SHALL implement states IDLE, PLAY and GAP, with every output registered.
REQ-016 In IDLE with any req bit high at cycle T, the block SHALL grant the lowest-index asserted bit and drive ack[i]=1 for exactly cycle T+1 only.
REQ-017 At grant, the block SHALL latch div_i and dur_i, and later changes on the inputs SHALL NOT affect the tone in progress.
REQ-018 Grant SHALL move the state to PLAY at T+1 and restart both the tick prescaler and the half-period counter from 0.
REQ-019 PLAY SHALL last exactly dur*TICK_DIV cycles, T+1 through T+dur*TICK_DIV inclusive.
REQ-020 In PLAY with div>0, fm SHALL be low for the first div cycles and then toggle every div cycles, giving a period of 2*div cycles.
REQ-021 In PLAY with div=0, fm SHALL stay high (silent tone), and the duration SHALL still be timed.
REQ-022 With dur=0, PLAY SHALL last one cycle with fm high, then enter GAP.
REQ-023 On leaving PLAY normally, the block SHALL pulse done[i] in the first GAP cycle and drive fm high.
REQ-024 GAP SHALL last GAP_TICKS*TICK_DIV cycles with fm high, then return to IDLE.
REQ-025 Requests SHALL be sampled only in IDLE, and no request SHALL be granted in PLAY or GAP.
REQ-026 There SHALL be no preemption: a higher-priority req arriving during PLAY SHALL wait for IDLE.
REQ-027 When stop is high in PLAY or GAP, the next cycle SHALL be IDLE with fm=1, and no done pulse SHALL be issued.
REQ-028 Stop SHALL take precedence over a simultaneous PLAY-to-GAP or GAP-to-IDLE transition.
REQ-029 When stop is high in IDLE with req high, stop SHALL win and no grant SHALL be made in that cycle.
REQ-030 The prescaler and half-period counters SHALL be sized from TICK_DIV and DIV_W, and SHALL NOT wrap within a legal tone.
REQ-031 A deasserted req in IDLE SHALL have no effect, and a requester SHALL receive at most one ack per IDLE visit.

Reset
REQ-032 While rst_n is low, the block SHALL hold state IDLE, fm=1, ack=0, done=0, busy=0, and all counters and latched div/dur at 0.
REQ-033 Reset asserted mid-tone SHALL force fm=1 immediately (asynchronously), and no done pulse SHALL follow.
REQ-034 After rst_n rises, the block SHALL grant no request before the first clk edge.

Verification
REQ-035 With TICK_DIV=50, req[1] with div1=25 and dur1=2 -> ack[1] one cycle; fm low 25, high 25, twice (100 cycles); done[1] at cycle 101; busy through the gap.
REQ-036 With req[0] and req[2] raised in the same cycle -> ack[0] only; req[2] is granted at the first IDLE after GAP ends.
REQ-037 With stop pulsed at cycle 10 of PLAY -> IDLE at cycle 11, fm=1, busy=0, no done; a pending req is granted the following cycle.
REQ-038 With div0=0 and dur0=3 -> fm high throughout; done[0] after 3*TICK_DIV cycles.
REQ-039 With dur2=0 -> one PLAY cycle, then done[2] and GAP.
REQ-040 With rst_n pulled low mid-PLAY while fm is low -> fm=1 without a clk edge; after release the block is IDLE and re-grants the held req.
